// File: rtl/reg_summer_if.sv
// Register-summer bus: start request/config, regfile read port and result outputs.
//   master : requester + regfile side (drives go/direction/base/rdata)
//   slave  : reg_summer side (drives rsnum/sum/busy/done/ovf)
interface reg_summer_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          go;
  logic          direction;
  logic [AW-1:0] base;
  logic [DW-1:0] rdata;
  logic [AW-1:0] rsnum;
  logic [DW-1:0] sum;
  logic          busy;
  logic          done;
  logic          ovf;

  modport master (
    output go, direction, base, rdata,
    input  rsnum, sum, busy, done, ovf
  );

  modport slave (
    input  go, direction, base, rdata,
    output rsnum, sum, busy, done, ovf
  );
endinterface

// File: rtl/reg_summer.sv
// reg_summer: reads NUM_REGS consecutive registers (ascending or descending,
// modulo 32) through a combinational regfile read port and accumulates them.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   bus.slave  go/direction/base/rdata in; rsnum/sum/busy/done/ovf out
// Optional feature: define REG_SUMMER_OVF_EN to build the sticky carry-out
// flag on ovf; otherwise ovf is tied to 0 and no carry logic exists.
module reg_summer #(
  parameter int unsigned NUM_REGS = 6
) (
  input  logic         clock,
  input  logic         reset,
  reg_summer_if.slave  bus
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Adder for the running sum; carry bit only exists when ovf is enabled.
`ifdef REG_SUMMER_OVF_EN
  logic          ovf_q, ovf_d;
  logic [DW:0]   add_c;
  assign add_c = {1'b0, sum_q} + {1'b0, bus.rdata};
`else
  logic [DW-1:0] add_c;
  assign add_c = sum_q + bus.rdata;
`endif

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_SUMMER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REG_SUMMER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update; busy/done are registered from next state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    count_d = count_q;
`ifdef REG_SUMMER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          state_d = READ;
          addr_d  = bus.base;
          sum_d   = '0;
          count_d = '0;
`ifdef REG_SUMMER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      READ: begin
        sum_d   = add_c[DW-1:0];
`ifdef REG_SUMMER_OVF_EN
        ovf_d   = ovf_q | add_c[DW];
`endif
        addr_d  = bus.direction ? addr_q - AW'(1) : addr_q + AW'(1);
        count_d = count_q + CW'(1);
        if (count_q == CW'(NUM_REGS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == READ);
    done_d = (state_d == DONE);
  end

  assign bus.rsnum = addr_q;
  assign bus.sum   = sum_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
`ifdef REG_SUMMER_OVF_EN
  assign bus.ovf   = ovf_q;
`else
  assign bus.ovf   = 1'b0;
`endif

endmodule

// File: doc/reg_summer.md
REG_SUMMER -- requirements
Module: reg_summer

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-002 Parameter: NUM_REGS, default 6, number of consecutive registers read per run; legal range 1..32.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 go  input  1  start request, sampled only in IDLE.
REQ-006 direction  input  1  0 = ascending register numbers, 1 = descending.
REQ-007 base  input  5  first register number, sampled with go.
REQ-008 rdata  input  32  regfile read-port data for rsnum, combinational, same cycle.
REQ-009 rsnum  output  5  register number driven to the regfile read port.
REQ-010 sum  output  32  running/final accumulated sum.
REQ-011 busy  output  1  high while in READ.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 ovf  output  1  unsigned overflow flag (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, READ, DONE.
REQ-015 IDLE with go=1 at an edge SHALL load addr<=base, sum<=0, count<=0, ovf<=0, and move to READ; IDLE with go=0 SHALL hold all registers.
REQ-016 rsnum SHALL equal the internal addr register in every state.
REQ-017 Each READ edge SHALL do sum<=sum+rdata (mod 2^32), addr<=addr+1 (direction=0) or addr-1 (direction=1) mod 32, count<=count+1.
REQ-018 direction SHALL be sampled every READ cycle; it is held constant by the user during a run.
REQ-019 Address wrap: 31+1 -> 0, 0-1 -> 31, no other effect.
REQ-020 READ SHALL go to DONE on the edge where count==NUM_REGS-1, i.e. after exactly NUM_REGS accumulations.
REQ-021 DONE SHALL last one cycle with done=1 and go to IDLE unconditionally.
REQ-022 Latency: done is high in the cycle following the NUM_REGS-th edge after the go-accept edge.
REQ-023 go in READ or DONE SHALL be ignored; no restart, no queueing.
REQ-024 sum and ovf SHALL hold their final values in IDLE until the next accepted go.
REQ-025 busy SHALL be 1 only in READ; done SHALL be 1 only in DONE.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, rsnum=0, sum=0, count=0, done=0, busy=0, ovf=0, with priority over go and any state.
REQ-027 Reset during READ or DONE SHALL abort the run with no done pulse.

Configuration
REQ-028 Macro REG_SUMMER_OVF_EN: when defined, ovf SHALL set sticky when any READ addition produces carry out of bit 31, cleared on reset and on go accept.
REQ-029 Without REG_SUMMER_OVF_EN, ovf SHALL be constant 0 and no carry logic is built; all other behaviour identical.

Verification
REQ-030 Reset: reset=1 for 2 cycles -> rsnum=0, sum=0, done=0, busy=0, ovf=0.
REQ-031 Ascending: R1..R6=0xd00..0xd05, base=1, direction=0, go one cycle -> rsnum 1,2,3,4,5,6 on consecutive cycles, busy high 6 cycles, done one cycle, sum=0x00004E0F.
REQ-032 Descending wrap: R1=5, R0=0, R31=0x10, R30=0x20, R29=0x30, R28=0x40, base=1, direction=1 -> rsnum 1,0,31,30,29,28, sum=0x000000A5.
REQ-033 Busy go: during READ cycle 3 assert go with base=20 -> rsnum sequence and sum identical to REQ-031, exactly one done pulse.
REQ-034 Mid-run reset: assert reset in READ cycle 3 of REQ-031 -> next cycle IDLE, sum=0, busy=0, no done pulse; subsequent go gives sum=0x00004E0F.
REQ-035 Overflow: R1..R6=0xFFFFFFFF, base=1, direction=0 -> sum=0xFFFFFFFA; ovf=1 with REG_SUMMER_OVF_EN, ovf=0 without.
